// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions.
//   - Register-field slice positions inside the packed rs/rt/rd bundle.
//   - Default datapath width.
//   - MEM/WB control bundle type and its bubble value.
package mips_pkg;

  localparam int DATA_W = 32;

  localparam int RS_HI = 14;
  localparam int RS_LO = 10;
  localparam int RT_HI = 9;
  localparam int RT_LO = 5;
  localparam int RD_HI = 4;
  localparam int RD_LO = 0;

  // Control half of the MEM/WB register. md_zero forces the load-data
  // output to zero (bubble, reset, or misaligned access).
  typedef struct packed {
    logic [4:0] wreg;
    logic       regwrite;
    logic       memtoreg;
    logic       md_zero;
  } mem_wb_ctl_t;

  localparam mem_wb_ctl_t MEM_WB_BUBBLE = '{
    wreg:     5'd0,
    regwrite: 1'b0,
    memtoreg: 1'b0,
    md_zero:  1'b1
  };

endpackage

// File: rtl/data_mem.sv
// Synchronous single-port word RAM, read-before-write.
//   clk   : rising-edge clock
//   en    : port enable; when low neither read register nor array changes
//   we    : write enable (qualified by en)
//   addr  : word index
//   wdata : write data
//   rdata : registered read data (old contents on a simultaneous write)
module data_mem #(
  parameter int DATA_W    = mips_pkg::DATA_W,
  parameter int MEM_DEPTH = 64,
  parameter int AW        = $clog2(MEM_DEPTH)
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [MEM_DEPTH];
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (en) begin
      rdata_d = mem_q[addr];
    end
  end

  always_ff @(posedge clk) begin
    rdata_q <= rdata_d;
    if (en && we) begin
      mem_q[addr] <= wdata;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage plus MEM/WB pipeline register.
//   clk, reset (async, active-low)
//   stall_in / flush_in      : hazard-unit hold / bubble (flush wins)
//   ALU_Result_in            : byte address or ALU result
//   ReadData2_in             : store data
//   MemRead_in, MemWrite_in  : load / store
//   MemToReg_in, RegDest_in, RegWrite_in, rs_rt_rd_in : writeback control
//   WriteData_out, WriteReg_out, RegWrite_out : writeback bundle
//   ALU_Result_out, MemData_out               : forwarding / load data
//   addr_err_out             : sticky misaligned-access flag
module mem_wb_stage
  import mips_pkg::*;
#(
  parameter int DATA_W    = mips_pkg::DATA_W,
  parameter int MEM_DEPTH = 64,
  parameter int AW        = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall_in,
  input  logic              flush_in,
  input  logic [DATA_W-1:0] ALU_Result_in,
  input  logic [DATA_W-1:0] ReadData2_in,
  input  logic              MemRead_in,
  input  logic              MemWrite_in,
  input  logic              MemToReg_in,
  input  logic              RegDest_in,
  input  logic              RegWrite_in,
  input  logic [14:0]       rs_rt_rd_in,
  output logic [DATA_W-1:0] WriteData_out,
  output logic [4:0]        WriteReg_out,
  output logic              RegWrite_out,
  output logic [DATA_W-1:0] ALU_Result_out,
  output logic [DATA_W-1:0] MemData_out,
  output logic              addr_err_out
);

  logic [AW-1:0]     idx;
  logic              misaligned;
  logic [4:0]        sel_reg;
  logic              ram_we;
  logic [DATA_W-1:0] ram_rdata;
  logic              unused_rs;

  mem_wb_ctl_t       ctl_q, ctl_d;
  logic [DATA_W-1:0] alu_q, alu_d;
  logic              err_q, err_d;
  logic              rst_ok_q, rst_ok_d;

  assign idx        = ALU_Result_in[AW+1:2];
  assign misaligned = |ALU_Result_in[1:0];
  assign sel_reg    = RegDest_in ? rs_rt_rd_in[RD_HI:RD_LO]
                                 : rs_rt_rd_in[RT_HI:RT_LO];
  assign unused_rs  = ^rs_rt_rd_in[RS_HI:RS_LO];

  // rst_ok_q stays low through the first edge after reset release so a
  // store presented on that edge cannot reach the RAM.
  assign rst_ok_d = 1'b1;
  assign ram_we   = MemWrite_in & ~misaligned & ~stall_in & ~flush_in & rst_ok_q;

  // The RAM read register is the load-data half of MEM/WB; it holds on
  // stall via the port enable, and ctl_q.md_zero masks it to zero.
  data_mem #(
    .DATA_W    (DATA_W),
    .MEM_DEPTH (MEM_DEPTH),
    .AW        (AW)
  ) u_data_mem (
    .clk   (clk),
    .en    (~stall_in),
    .we    (ram_we),
    .addr  (idx),
    .wdata (ReadData2_in),
    .rdata (ram_rdata)
  );

  always_comb begin
    ctl_d = ctl_q;
    alu_d = alu_q;
    err_d = err_q;
    if (flush_in) begin
      ctl_d = MEM_WB_BUBBLE;
      alu_d = '0;
    end else if (!stall_in) begin
      ctl_d.wreg     = sel_reg;
      ctl_d.regwrite = RegWrite_in & (sel_reg != 5'd0) & ~(MemRead_in & misaligned);
      ctl_d.memtoreg = MemToReg_in;
      ctl_d.md_zero  = misaligned;
      alu_d          = ALU_Result_in;
      err_d          = err_q | ((MemRead_in | MemWrite_in) & misaligned);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctl_q    <= MEM_WB_BUBBLE;
      alu_q    <= '0;
      err_q    <= 1'b0;
      rst_ok_q <= 1'b0;
    end else begin
      ctl_q    <= ctl_d;
      alu_q    <= alu_d;
      err_q    <= err_d;
      rst_ok_q <= rst_ok_d;
    end
  end

  assign MemData_out    = ctl_q.md_zero ? '0 : ram_rdata;
  assign WriteData_out  = ctl_q.memtoreg ? MemData_out : alu_q;
  assign WriteReg_out   = ctl_q.wreg;
  assign RegWrite_out   = ctl_q.regwrite;
  assign ALU_Result_out = alu_q;
  assign addr_err_out   = err_q;

endmodule
